// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module alu_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exe_start,
   input  logic            exe_kill,
   input  logic [2:0]      exe_md_opc_r,
   input  logic [XLEN-1:0] exe_reg1_r,
   input  logic [XLEN-1:0] exe_src2_r,
   output logic            md_ready,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;

   logic            accept;
   logic            is_div;
   logic            sa, sb;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, ovf, special;
   logic [XLEN-1:0] spec_res;
   logic [XLEN:0]   msum;
   logic [XLEN:0]   dtmp, ddiff;
   logic            dge;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

   assign md_ready  = (state_q == IDLE) || (state_q == DONE);
   assign md_done   = (state_q == DONE);
   assign md_result = res_q;

   assign accept = exe_start && md_ready && !exe_kill;
   assign is_div = exe_md_opc_r[2];
   // MUL/MULH/MULHSU sign reg1; MUL/MULH sign src2; DIV/REM sign both.
   assign sa = is_div ? !exe_md_opc_r[0] : (exe_md_opc_r[1:0] != 2'b11);
   assign sb = is_div ? !exe_md_opc_r[0] : !exe_md_opc_r[1];
   assign a_neg = sa && exe_reg1_r[XLEN-1];
   assign b_neg = sb && exe_src2_r[XLEN-1];
   assign a_mag = a_neg ? -exe_reg1_r : exe_reg1_r;
   assign b_mag = b_neg ? -exe_src2_r : exe_src2_r;

   assign div_zero = is_div && (exe_src2_r == '0);
   assign ovf = is_div && !exe_md_opc_r[0] && (&exe_src2_r)
             && (exe_reg1_r == {1'b1, {(XLEN-1){1'b0}}});
   assign special = div_zero || ovf;
   assign spec_res = div_zero
                   ? (exe_md_opc_r[1] ? exe_reg1_r : '1)
                   : (exe_md_opc_r[1] ? '0 : exe_reg1_r);

   assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign dtmp  = {hi_q, lo_q[XLEN-1]};
   assign ddiff = dtmp - {1'b0, b_q};
   assign dge   = !ddiff[XLEN];

   assign prod     = {hi_q, lo_q};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -lo_q : lo_q;
   assign rem_fix  = rneg_q ? -hi_q : hi_q;
   assign fix_res  = op_q[2]
                   ? (op_q[1] ? rem_fix : quo_fix)
                   : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                          : prod_fix[2*XLEN-1:XLEN]);

   // Next-state, datapath step and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               op_d   = exe_md_opc_r;
               neg_d  = a_neg ^ b_neg;
               rneg_d = a_neg;
               hi_d   = '0;
               lo_d   = a_mag;
               b_d    = b_mag;
               cnt_d  = CW'(XLEN - 1);
               if (special) begin
                  res_d   = spec_res;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (op_q[2]) begin
               hi_d = dge ? ddiff[XLEN-1:0] : dtmp[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], dge};
            end else begin
               hi_d = msum[XLEN:1];
               lo_d = {msum[0], lo_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            res_d   = fix_res;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (exe_kill) begin
         state_d = IDLE;
         res_d   = res_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv.
// Covers XLEN=32 and XLEN=16 instances.
module tb_alu_muldiv;

   logic        clk;
   logic        rst;
   logic        start, kill;
   logic [2:0]  opc;
   logic [31:0] r1, r2;
   logic        rdy, done;
   logic [31:0] res;

   logic        s_start, s_kill;
   logic [2:0]  s_opc;
   logic [15:0] s_r1, s_r2;
   logic        s_rdy, s_done;
   logic [15:0] s_res;

   int checks = 0;
   int errors = 0;

   alu_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .exe_start(start), .exe_kill(kill),
      .exe_md_opc_r(opc),
      .exe_reg1_r(r1), .exe_src2_r(r2),
      .md_ready(rdy), .md_done(done), .md_result(res)
   );

   alu_muldiv #(.XLEN(16)) dut16 (
      .clk(clk), .rst(rst),
      .exe_start(s_start), .exe_kill(s_kill),
      .exe_md_opc_r(s_opc),
      .exe_reg1_r(s_r1), .exe_src2_r(s_r2),
      .md_ready(s_rdy), .md_done(s_done), .md_result(s_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b);
      opc   = o;
      r1    = a;
      r2    = b;
      start = 1'b1;
      step();
      start = 1'b0;
      opc   = 3'b111;
      r1    = 32'hDEAD_BEEF;
      r2    = 32'h0;
   endtask

   task automatic wait_done(input int c0, output int cyc, output int rb);
      cyc = c0;
      rb  = 0;
      while (!done && cyc < 200) begin
         if (rdy) rb++;
         step();
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", rdy);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b want 0", done);
      end
      checks++;
      if (res !== 32'h0) begin
         errors++;
         $display("FAIL reset_result got %h want 0", res);
      end
   endtask

   task automatic test_mul_basic();
      int cyc, rb;
      launch(3'b000, 32'd7, 32'hFFFF_FFFD);
      wait_done(1, cyc, rb);
      checks++;
      if (cyc !== 34) begin
         errors++;
         $display("FAIL mul_latency got %0d want 34", cyc);
      end
      checks++;
      if (rb !== 0) begin
         errors++;
         $display("FAIL mul_busy_ready got %0d want 0", rb);
      end
      checks++;
      if (res !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL mul_result got %h want ffffffeb", res);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL mul_done_pulse got %b want 0", done);
      end
   endtask

   task automatic test_mulhigh();
      logic [2:0]  o[3]  = '{3'b001, 3'b011, 3'b010};
      logic [31:0] a[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] b[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] e[3]  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      int cyc, rb;
      for (int i = 0; i < 3; i++) begin
         launch(o[i], a[i], b[i]);
         wait_done(1, cyc, rb);
         checks++;
         if (res !== e[i] || cyc !== 34) begin
            errors++;
            $display("FAIL mulhigh%0d got %h/%0d want %h/34",
                     i, res, cyc, e[i]);
         end
         step();
      end
   endtask

   task automatic test_div();
      logic [2:0]  o[4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] b[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] e[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int cyc, rb;
      for (int i = 0; i < 4; i++) begin
         launch(o[i], a[i], b[i]);
         wait_done(1, cyc, rb);
         checks++;
         if (res !== e[i] || cyc !== 34) begin
            errors++;
            $display("FAIL div%0d got %h/%0d want %h/34",
                     i, res, cyc, e[i]);
         end
         step();
      end
   endtask

   task automatic test_special();
      logic [2:0]  o[4]  = '{3'b101, 3'b111, 3'b100, 3'b110};
      logic [31:0] a[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] e[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int cyc, rb;
      for (int i = 0; i < 4; i++) begin
         launch(o[i], a[i], b[i]);
         wait_done(1, cyc, rb);
         checks++;
         if (res !== e[i] || cyc !== 1) begin
            errors++;
            $display("FAIL special%0d got %h/%0d want %h/1",
                     i, res, cyc, e[i]);
         end
         step();
      end
   endtask

   task automatic test_kill();
      int cyc, rb, nd;
      launch(3'b101, 32'd100, 32'd7);
      wait_done(1, cyc, rb);
      checks++;
      if (res !== 32'd14) begin
         errors++;
         $display("FAIL kill_pre got %h want 0000000e", res);
      end
      step();
      launch(3'b100, 32'hFFFF_FFF9, 32'd2);
      for (int i = 1; i < 10; i++) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      checks++;
      if (rdy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL kill_state got rdy=%b done=%b want 1/0", rdy, done);
      end
      start = 1'b1;
      kill  = 1'b1;
      opc   = 3'b000;
      r1    = 32'd3;
      r2    = 32'd4;
      step();
      start = 1'b0;
      kill  = 1'b0;
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL kill_drops_start got rdy=%b want 1", rdy);
      end
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         step();
      end
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL kill_no_done got %0d want 0", nd);
      end
      checks++;
      if (res !== 32'd14) begin
         errors++;
         $display("FAIL kill_hold got %h want 0000000e", res);
      end
   endtask

   task automatic test_reset_mid();
      int nd;
      launch(3'b100, 32'hFFFF_FFF9, 32'd2);
      for (int i = 1; i < 10; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (res !== 32'h0 || rdy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got res=%h rdy=%b done=%b want 0/1/0",
                  res, rdy, done);
      end
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         step();
      end
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL rst_mid_no_done got %0d want 0", nd);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, rb;
      launch(3'b000, 32'd3, 32'd4);
      wait_done(1, cyc, rb);
      checks++;
      if (res !== 32'd12 || cyc !== 34) begin
         errors++;
         $display("FAIL b2b_first got %h/%0d want 0000000c/34", res, cyc);
      end
      launch(3'b101, 32'd9, 32'd2);
      wait_done(1, cyc, rb);
      checks++;
      if (res !== 32'd4 || cyc + 34 !== 68) begin
         errors++;
         $display("FAIL b2b_second got %h/%0d want 00000004/68",
                  res, cyc + 34);
      end
      step();
   endtask

   task automatic test_ignored_start();
      int cyc, rb;
      launch(3'b101, 32'd100, 32'd7);
      for (int i = 1; i < 5; i++) step();
      start = 1'b1;
      opc   = 3'b000;
      r1    = 32'd3;
      r2    = 32'd4;
      step();
      start = 1'b0;
      wait_done(6, cyc, rb);
      checks++;
      if (res !== 32'd14 || cyc !== 34 || rb !== 0) begin
         errors++;
         $display("FAIL ignored_start got %h/%0d/%0d want 0000000e/34/0",
                  res, cyc, rb);
      end
      step();
      checks++;
      if (done !== 1'b0 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL ignored_start_idle got done=%b rdy=%b want 0/1",
                  done, rdy);
      end
   endtask

   task automatic test_xlen16();
      int cyc;
      s_opc   = 3'b000;
      s_r1    = 16'h00FF;
      s_r2    = 16'h0101;
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      s_r1    = 16'h1234;
      s_r2    = 16'h0;
      cyc = 1;
      while (!s_done && cyc < 100) begin
         step();
         cyc++;
      end
      if (!s_done) cyc = -1;
      checks++;
      if (cyc !== 18) begin
         errors++;
         $display("FAIL x16_latency got %0d want 18", cyc);
      end
      checks++;
      if (s_res !== 16'hFFFF) begin
         errors++;
         $display("FAIL x16_result got %h want ffff", s_res);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      kill    = 1'b0;
      opc     = 3'b000;
      r1      = 32'h0;
      r2      = 32'h0;
      s_start = 1'b0;
      s_kill  = 1'b0;
      s_opc   = 3'b000;
      s_r1    = 16'h0;
      s_r2    = 16'h0;
      test_reset();
      test_mul_basic();
      test_mulhigh();
      test_div();
      test_special();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      test_ignored_start();
      test_xlen16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
